// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational lookup, single-cycle update, NUM_SETS-cycle flush.
// Lookup is same-cycle; updates visible next cycle. Flush asserts busy and blocks lookups/updates.
module btb_assoc #(
    parameter int XLEN     = 32,
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_lookup,
    input  logic            lookup_en,
    input  logic            update_en,
    input  logic [XLEN-1:0] pc_update,
    input  logic [XLEN-1:0] target_actual,
    input  logic            is_branch_or_jmp,
    input  logic            is_uncond,
    input  logic            taken_actual,
    input  logic            flush_req,
    output logic            hit,
    output logic            predict_taken,
    output logic [XLEN-1:0] target_predicted,
    output logic            busy
);

    localparam int IW = $clog2(NUM_SETS);
    localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TW = XLEN - IW - 2;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t              state;
    logic [IW-1:0]       flush_cnt;

    logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
    logic [1:0]          ctr_q    [NUM_SETS][NUM_WAYS];
    logic [WW-1:0]       victim_q [NUM_SETS];
    logic [TW-1:0]       tag_q    [NUM_SETS][NUM_WAYS];
    logic [XLEN-1:0]     tgt_q    [NUM_SETS][NUM_WAYS];
    logic                uncond_q [NUM_SETS][NUM_WAYS];

    logic [IW-1:0]       lk_idx;
    logic [TW-1:0]       lk_tag;
    logic [NUM_WAYS-1:0] lk_match;
    logic [WW-1:0]       lk_way;

    logic [IW-1:0]       up_idx;
    logic [TW-1:0]       up_tag;
    logic [NUM_WAYS-1:0] up_match;
    logic [WW-1:0]       up_hit_way;
    logic                free_found;
    logic [WW-1:0]       free_way;
    logic                up_ok;
    logic                wr_hit;
    logic                wr_alloc;
    logic                wr_en;
    logic [WW-1:0]       wr_way;
    logic                bump_victim;
    logic [WW-1:0]       victim_next;
    logic [1:0]          ctr_cur;
    logic [1:0]          ctr_next;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc_lookup[1:0], pc_update[1:0]};

    assign busy   = (state == FLUSH);

    assign lk_idx = pc_lookup[IW+1:2];
    assign lk_tag = pc_lookup[XLEN-1:IW+2];

    always_comb begin
        lk_match = '0;
        lk_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_match[w] = 1'b1;
                lk_way      = WW'(w);
            end
        end
    end

    // Multiple matching ways are treated as a miss rather than picking one arbitrarily.
    assign hit              = lookup_en && !busy && $onehot(lk_match);
    assign predict_taken    = hit && (uncond_q[lk_idx][lk_way] || ctr_q[lk_idx][lk_way][1]);
    assign target_predicted = predict_taken ? tgt_q[lk_idx][lk_way] : pc_lookup + XLEN'(4);

    assign up_idx = pc_update[IW+1:2];
    assign up_tag = pc_update[XLEN-1:IW+2];

    always_comb begin
        up_match   = '0;
        up_hit_way = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
                up_match[w] = 1'b1;
                up_hit_way  = WW'(w);
            end
        end
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[up_idx][w]) begin
                free_found = 1'b1;
                free_way   = WW'(w);
            end
        end
    end

    // A flush request in IDLE takes priority and drops any coincident update.
    assign up_ok       = update_en && is_branch_or_jmp && (state == IDLE) && !flush_req;
    assign wr_hit      = up_ok && (|up_match);
    assign wr_alloc    = up_ok && !(|up_match) && taken_actual;
    assign wr_en       = wr_hit || wr_alloc;
    assign wr_way      = wr_hit ? up_hit_way : (free_found ? free_way : victim_q[up_idx]);
    assign bump_victim = wr_alloc && !free_found;
    assign victim_next = (victim_q[up_idx] == WW'(NUM_WAYS - 1)) ? '0 : victim_q[up_idx] + WW'(1);
    assign ctr_cur     = ctr_q[up_idx][wr_way];

    always_comb begin
        ctr_next = ctr_cur;
        if (wr_alloc) begin
            ctr_next = 2'b10;
        end else if (taken_actual) begin
            ctr_next = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
        end else begin
            ctr_next = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            flush_cnt <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s]  <= '0;
                victim_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    ctr_q[s][w] <= 2'b00;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    valid_q[flush_cnt]  <= '0;
                    victim_q[flush_cnt] <= '0;
                    flush_cnt           <= flush_cnt + IW'(1);
                    if (flush_cnt == IW'(NUM_SETS - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr_en) begin
                valid_q[up_idx][wr_way] <= 1'b1;
                ctr_q[up_idx][wr_way]   <= ctr_next;
            end
            if (bump_victim) begin
                victim_q[up_idx] <= victim_next;
            end
        end
    end

    // Payload storage needs no reset; it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[up_idx][wr_way]    <= up_tag;
            tgt_q[up_idx][wr_way]    <= target_actual;
            uncond_q[up_idx][wr_way] <= is_uncond;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Randomized and directed bench for btb_assoc against a table-based reference model.
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_lookup;
    logic        lookup_en;
    logic        update_en;
    logic [31:0] pc_update;
    logic [31:0] target_actual;
    logic        is_branch_or_jmp;
    logic        is_uncond;
    logic        taken_actual;
    logic        flush_req;
    logic        hit;
    logic        predict_taken;
    logic [31:0] target_predicted;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 16 sets x 2 ways, tag kept as pc>>6.
    bit          m_valid [16][2];
    logic [31:0] m_tag   [16][2];
    logic [31:0] m_tgt   [16][2];
    int          m_ctr   [16][2];
    bit          m_unc   [16][2];
    int          m_vic   [16];
    int          busy_left;

    bit          o_hit;
    bit          o_pt;
    logic [31:0] o_tgt;
    bit          o_busy;

    btb_assoc #(.XLEN(32), .NUM_SETS(16), .NUM_WAYS(2)) dut (
        .clk(clk), .reset(reset),
        .pc_lookup(pc_lookup), .lookup_en(lookup_en),
        .update_en(update_en), .pc_update(pc_update), .target_actual(target_actual),
        .is_branch_or_jmp(is_branch_or_jmp), .is_uncond(is_uncond), .taken_actual(taken_actual),
        .flush_req(flush_req),
        .hit(hit), .predict_taken(predict_taken), .target_predicted(target_predicted), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < 16; s++) begin
            m_vic[s] = 0;
            for (int w = 0; w < 2; w++) m_valid[s][w] = 0;
        end
        busy_left = 0;
    endtask

    task automatic m_lookup(input bit en, input logic [31:0] pc,
                            output bit h, output bit pt, output logic [31:0] t);
        int s, n, way;
        s = int'(pc[5:2]);
        n = 0;
        way = 0;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == (pc >> 6)) begin n++; way = w; end
        h  = en && busy_left == 0 && n == 1;
        pt = h && (m_unc[s][way] || m_ctr[s][way] >= 2);
        t  = pt ? m_tgt[s][way] : pc + 32'd4;
    endtask

    task automatic m_update(input bit ue, input logic [31:0] pc, input logic [31:0] ta,
                            input bit br, input bit unc, input bit tk, input bit fl);
        int s, hw, fw;
        if (busy_left > 0) begin
            busy_left--;
            return;
        end
        if (fl) begin
            // Whole table becomes invisible at once; the walk is hidden behind busy.
            m_reset();
            busy_left = 16;
            return;
        end
        if (!(ue && br)) return;
        s  = int'(pc[5:2]);
        hw = -1;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == (pc >> 6)) hw = w;
        if (hw >= 0) begin
            m_tgt[s][hw] = ta;
            m_unc[s][hw] = unc;
            if (tk) m_ctr[s][hw] = (m_ctr[s][hw] == 3) ? 3 : m_ctr[s][hw] + 1;
            else    m_ctr[s][hw] = (m_ctr[s][hw] == 0) ? 0 : m_ctr[s][hw] - 1;
        end else if (tk) begin
            fw = -1;
            for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) fw = w;
            if (fw < 0) begin
                fw = m_vic[s];
                m_vic[s] = (m_vic[s] + 1) % 2;
            end
            m_valid[s][fw] = 1;
            m_tag[s][fw]   = pc >> 6;
            m_tgt[s][fw]   = ta;
            m_unc[s][fw]   = unc;
            m_ctr[s][fw]   = 2;
        end
    endtask

    task automatic cycle(input bit le, input logic [31:0] pl, input bit ue, input logic [31:0] pu,
                         input logic [31:0] ta, input bit br, input bit unc, input bit tk, input bit fl);
        bit eh, ep;
        logic [31:0] et;
        @(negedge clk);
        lookup_en = le; pc_lookup = pl;
        update_en = ue; pc_update = pu; target_actual = ta;
        is_branch_or_jmp = br; is_uncond = unc; taken_actual = tk; flush_req = fl;
        #1;
        m_lookup(le, pl, eh, ep, et);
        o_hit = hit; o_pt = predict_taken; o_tgt = target_predicted; o_busy = busy;
        chk("hit", 64'(hit), 64'(eh));
        chk("predict_taken", 64'(predict_taken), 64'(ep));
        chk("target", 64'(target_predicted), 64'(et));
        chk("busy", 64'(busy), 64'(busy_left > 0));
        @(posedge clk);
        m_update(ue, pu, ta, br, unc, tk, fl);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] ta, input bit unc, input bit tk);
        cycle(1'b0, 32'h0, 1'b1, pc, ta, 1'b1, unc, tk, 1'b0);
    endtask

    task automatic look(input logic [31:0] pc);
        cycle(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] rp, rq;
        reset = 1'b0;
        lookup_en = 1'b1; pc_lookup = 32'h100;
        update_en = 1'b0; pc_update = 32'h0; target_actual = 32'h0;
        is_branch_or_jmp = 1'b0; is_uncond = 1'b0; taken_actual = 1'b0; flush_req = 1'b0;
        m_reset();
        #3;
        chk("rst_hit", 64'(hit), 64'h0);
        chk("rst_pt", 64'(predict_taken), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_tgt", 64'(target_predicted), 64'h104);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Taken update, same-cycle lookup sees old contents, next cycle hits.
        cycle(1'b1, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("same_cycle_miss", 64'(o_hit), 64'h0);
        look(32'h100);
        chk("d37_hit", 64'(o_hit), 64'h1);
        chk("d37_pt", 64'(o_pt), 64'h1);
        chk("d37_tgt", 64'(o_tgt), 64'h200);

        // Two not-taken updates drive the counter to 0.
        upd(32'h100, 32'h200, 1'b0, 1'b0);
        upd(32'h100, 32'h200, 1'b0, 1'b0);
        look(32'h100);
        chk("d38_hit", 64'(o_hit), 64'h1);
        chk("d38_pt", 64'(o_pt), 64'h0);
        chk("d38_tgt", 64'(o_tgt), 64'h104);

        // Round-robin replacement in set 0.
        upd(32'h140, 32'h240, 1'b0, 1'b1);
        upd(32'h180, 32'h280, 1'b0, 1'b1);
        look(32'h100);
        chk("d39_evict100", 64'(o_hit), 64'h0);
        look(32'h140);
        chk("d39_keep140", 64'(o_hit), 64'h1);
        upd(32'h1C0, 32'h2C0, 1'b0, 1'b1);
        look(32'h140);
        chk("d39_evict140", 64'(o_hit), 64'h0);
        look(32'h180);
        chk("d39_keep180", 64'(o_tgt), 64'h280);

        // Unconditional jump stays predicted taken after a not-taken update.
        upd(32'h300, 32'h80, 1'b1, 1'b1);
        upd(32'h300, 32'h80, 1'b1, 1'b0);
        look(32'h300);
        chk("d40_pt", 64'(o_pt), 64'h1);
        chk("d40_tgt", 64'(o_tgt), 64'h80);

        // Flush: coincident update and updates during the walk are dropped.
        upd(32'h104, 32'h400, 1'b0, 1'b1);
        upd(32'h108, 32'h500, 1'b0, 1'b1);
        cycle(1'b1, 32'h104, 1'b1, 32'h10C, 32'h600, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'h104, 1'b1, 32'h110, 32'h700, 1'b1, 1'b0, 1'b1, (i == 3));
            chk("d41_busy", 64'(o_busy), 64'h1);
            chk("d41_hit", 64'(o_hit), 64'h0);
        end
        look(32'h104);
        chk("d41_done", 64'(o_busy), 64'h0);
        chk("d41_miss104", 64'(o_hit), 64'h0);
        look(32'h110);
        chk("d41_miss110", 64'(o_hit), 64'h0);
        look(32'h10C);
        chk("d41_miss10C", 64'(o_hit), 64'h0);

        // Reset between edges during a flush.
        upd(32'h120, 32'h900, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) look(32'h120);
        @(negedge clk);
        lookup_en = 1'b1; pc_lookup = 32'h120; flush_req = 1'b0; update_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("d42_busy", 64'(busy), 64'h0);
        chk("d42_hit", 64'(hit), 64'h0);
        chk("d42_tgt", 64'(target_predicted), 64'h124);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        upd(32'h120, 32'h600, 1'b0, 1'b1);
        look(32'h120);
        chk("d42_hit_after", 64'(o_hit), 64'h1);
        chk("d42_tgt_after", 64'(o_tgt), 64'h600);

        // Random traffic on a small PC pool to force contention and hits.
        for (int i = 0; i < 800; i++) begin
            rp = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2);
            rq = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2);
            cycle($urandom_range(0, 7) != 0, rp,
                  $urandom_range(0, 1) == 1, rq, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 79) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter XLEN, default 32, address and target width.
REQ-002 SHALL have parameter NUM_SETS, default 16, set count (power of two, at least 2).
REQ-003 SHALL have parameter NUM_WAYS, default 2, associativity (power of two, 1..8).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset; assertion clears state immediately regardless of clk.
REQ-006 SHALL have port pc_lookup  input  XLEN  IF-stage fetch PC.
REQ-007 SHALL have port lookup_en  input  1  lookup qualifier.
REQ-008 SHALL have port update_en  input  1  EX-stage resolution valid.
REQ-009 SHALL have port pc_update  input  XLEN  PC of the resolved instruction.
REQ-010 SHALL have port target_actual  input  XLEN  resolved target.
REQ-011 SHALL have port is_branch_or_jmp  input  1  resolved instruction is a control transfer.
REQ-012 SHALL have port is_uncond  input  1  resolved instruction is an unconditional jump.
REQ-013 SHALL have port taken_actual  input  1  resolved direction.
REQ-014 SHALL have port flush_req  input  1  single-cycle request to invalidate all entries.
REQ-015 SHALL have port hit  output  1  valid tag match in the indexed set.
REQ-016 SHALL have port predict_taken  output  1  predicted direction.
REQ-017 SHALL have port target_predicted  output  XLEN  predicted next PC.
REQ-018 SHALL have port busy  output  1  flush in progress.

Function
REQ-019 SHALL use index = pc[IW+1:2] and tag = pc[XLEN-1:IW+2], where IW = log2(NUM_SETS).
REQ-020 SHALL hold per entry: valid, tag, target, 2-bit saturating counter, uncond bit; SHALL hold one round-robin victim pointer (log2(NUM_WAYS) bits) per set.
REQ-021 SHALL compute lookup combinationally: hit=1 only when lookup_en=1, busy=0, and exactly one valid way in the set matches the tag.
REQ-022 SHALL drive predict_taken = hit AND (uncond OR counter[1]).
REQ-023 SHALL drive target_predicted = stored target when predict_taken=1, else pc_lookup+4 (modulo 2^XLEN).
REQ-024 SHALL apply writes only when update_en=1, is_branch_or_jmp=1 and busy=0; writes are visible to lookups from the next cycle; a same-cycle lookup sees the old contents.
REQ-025 SHALL, on an update tag hit: write target, write uncond, and increment the counter if taken_actual=1 (saturating at 3) or decrement it otherwise (saturating at 0).
REQ-026 SHALL, on an update tag miss with taken_actual=1: allocate the lowest-numbered invalid way; if no way is invalid, allocate the way given by the victim pointer and then increment that pointer modulo NUM_WAYS. The new entry gets valid=1, tag, target, uncond, and counter=2'b10.
REQ-027 SHALL NOT allocate on an update tag miss with taken_actual=0.
REQ-028 SHALL implement a two-state FSM IDLE/FLUSH: flush_req=1 in IDLE moves to FLUSH with a set counter of 0.
REQ-029 SHALL, in FLUSH, clear all valid bits and the victim pointer of set[counter] each cycle; after set NUM_SETS-1 is cleared, return to IDLE, taking exactly NUM_SETS cycles.
REQ-030 SHALL drive busy=1 exactly while in FLUSH.
REQ-031 SHALL ignore flush_req while in FLUSH.
REQ-032 SHALL give priority to flush_req in IDLE when it coincides with a valid update; that update is dropped.

Reset
REQ-033 SHALL, on reset assertion: clear all valid bits, victim pointers, counters and the flush counter; set FSM=IDLE.
REQ-034 SHALL, during reset, hold hit=0, predict_taken=0, busy=0, and target_predicted=pc_lookup+4.
REQ-035 SHALL NOT be required to reset tag, target or uncond storage.
REQ-036 SHALL abandon an in-progress flush on reset and resume in IDLE after release.

Verification (NUM_SETS=16, NUM_WAYS=2)
REQ-037 SHALL cover: taken update pc=0x100, target=0x200 -> next cycle lookup 0x100 gives hit=1, predict_taken=1, target=0x200.
REQ-038 SHALL cover: two not-taken updates to 0x100 -> counter reaches 0; lookup gives hit=1, predict_taken=0, target=0x104.
REQ-039 SHALL cover: taken updates 0x100, 0x140, 0x180 (all set 0) -> 0x180 replaces way 0 (0x100 misses); a further 0x1C0 replaces way 1 (0x140 misses).
REQ-040 SHALL cover: uncond jump 0x300 -> 0x80, then a not-taken update -> predict_taken stays 1.
REQ-041 SHALL cover: fill entries, pulse flush_req -> busy=1 for 16 cycles and hit=0; an update during the flush is dropped; all lookups miss afterward.
REQ-042 SHALL cover: reset asserted mid-flush between clock edges -> busy=0 immediately; after release, a taken update allocates normally.
